// File: rtl/mdu_seq_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcodes, FSM states,
// default width and small opcode classification helpers.
package mdu_seq_ctrl_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  // 3-bit md_op encodings issued by decode.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  // True for the multi-cycle multiply/divide class.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for DIV/DIVU.
  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the signed variants MULT/DIV.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_seq_ctrl_step.sv
// One combinational iteration of the shared datapath.
// Multiply: {acc,mq} holds the partial product; add opnd if mq LSB set, shift right.
// Divide:   acc is the partial remainder, mq shifts the dividend out and
//           quotient bits in (restoring compare-subtract).
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // Select one multiply or divide step for the current operation.
  always_comb begin
    mul_sum   = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    div_shift = {acc_i, mq_i[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_i});
    // The remainder after a successful subtract is below opnd, so the
    // truncated difference is exact.
    div_diff  = div_shift[WIDTH-1:0] - opnd_i;

    if (is_div) begin
      acc_o = div_ge ? div_diff : div_shift[WIDTH-1:0];
      mq_o  = {mq_i[WIDTH-2:0], div_ge};
    end else begin
      acc_o = mul_sum[WIDTH:1];
      mq_o  = {mul_sum[0], mq_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO ownership.
// IDLE -> PREP -> ITER (WIDTH steps) -> FIX -> DONE -> IDLE; MTHI/MTLO in IDLE.
module mdu_seq_ctrl
  import mdu_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_mq;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [2*WIDTH-1:0] prod;
  logic               op_div;
  logic               b_zero;

  assign op_div = md_is_div(op_q);
  assign b_zero = (b_q == '0);

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div(op_div),
    .acc_i (acc_q),
    .mq_i  (mq_q),
    .opnd_i(opnd_q),
    .acc_o (step_acc),
    .mq_o  (step_mq)
  );

  // Sign-correct the unsigned iteration result into final HI/LO values.
  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    prod   = {acc_q, mq_q};
    if (op_div) begin
      if (b_zero) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        // INT_MIN / -1 falls out naturally: |q| = 2^(W-1), negation wraps to itself.
        fix_lo = (neg_a_q ^ neg_b_q) ? (-mq_q) : mq_q;
        fix_hi = neg_a_q ? (-acc_q) : acc_q;
      end
    end else begin
      if (neg_a_q ^ neg_b_q) begin
        prod = -prod;
      end
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // Next-state, datapath loads and HI/LO updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    abs_a   = a_q;
    abs_b   = b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (md_is_arith(md_op)) begin
            op_d    = md_op;
            a_d     = src_a;
            b_d     = src_b;
            state_d = ST_PREP;
          end else if (md_op == MD_MTHI) begin
            hi_d = src_a;
          end else if (md_op == MD_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      ST_PREP: begin
        neg_a_d = md_is_signed(op_q) & a_q[WIDTH-1];
        neg_b_d = md_is_signed(op_q) & b_q[WIDTH-1];
        abs_a   = neg_a_d ? (-a_q) : a_q;
        abs_b   = neg_b_d ? (-b_q) : b_q;
        acc_d   = '0;
        cnt_d   = '0;
        if (op_div) begin
          mq_d   = abs_a;
          opnd_d = abs_b;
        end else begin
          mq_d   = abs_b;
          opnd_d = abs_a;
        end
        state_d = ST_ITER;
      end
      ST_ITER: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides everything, including an IDLE start or MTHI/MTLO and
    // the FIX-cycle HI/LO write.
    if (flush) begin
      state_d = ST_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status outputs decode straight from registered state.
  always_comb begin
    busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
    done        = (state_q == ST_DONE);
    div_by_zero = done && op_div && b_zero;
    hi          = hi_q;
    lo          = lo_q;
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Self-checking bench for mdu_seq_ctrl: directed corner cases plus random
// MULT/MULTU/DIV/DIVU against an arithmetic reference model.
module tb_mdu_seq_ctrl;
  import mdu_seq_ctrl_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned LATENCY = 35;  // done cycle, counting the issue cycle as 0

  logic          clock;
  logic          rst_n;
  logic          start;
  logic [2:0]    md_op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          flush;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_seq_ctrl #(
    .WIDTH(W)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .md_op      (md_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A start issued while busy must not disturb the in-flight operation.
  assert property (@(posedge clock) disable iff (!rst_n)
                   (busy && start && !flush) |=> (busy || done))
  else begin
    n_fail++;
    $display("FAIL start_while_busy: busy/done dropped after ignored start");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    z = 1'b0;
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      MD_DIV: begin
        if (b == 0) begin
          z = 1'b1; h = a; l = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = '0;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      MD_DIVU: begin
        if (b == 0) begin
          z = 1'b1; h = a; l = '1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue one arithmetic op, watch it to completion and check the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke_busy);
    logic [W-1:0] eh, el, prev_hi, prev_lo;
    logic         ez;
    int           edges;
    bit           busy_ok, hold_ok;
    model(op, a, b, eh, el, ez);
    @(negedge clock);
    prev_hi = hi;
    prev_lo = lo;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clock); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    edges = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && edges < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      start = poke_busy && (edges == 20);
      if (start) begin
        md_op = MD_MTLO;
      end
      @(posedge clock); #1;
      edges++;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, 64'(edges), 64'(LATENCY));
    check_eq({tag, "_busy_while_running"}, 64'(busy_ok), 64'd1);
    check_eq({tag, "_hilo_held"}, 64'(hold_ok), 64'd1);
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo), 64'(el));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    @(posedge clock); #1;
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  logic [W-1:0] sav_hi, sav_lo;
  bit           no_done;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = '0; src_a = '0; src_b = '0;
    #23;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    @(negedge clock); rst_n = 1'b1;

    // Directed corner cases.
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_eq("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check_eq("multu_max_lo_const", 64'(lo), 64'h0000_0001);
    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    check_eq("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    check_eq("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_op("divu_zero", MD_DIVU, 32'd100, 32'd0, 1'b0);
    run_op("div_zero", MD_DIV, 32'h8000_0005, 32'd0, 1'b0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_busy_poke", MD_DIVU, 32'hDEAD_BEEF, 32'd13, 1'b1);

    // MTHI then MTLO on consecutive edges.
    @(negedge clock);
    start = 1'b1; md_op = MD_MTHI; src_a = 32'h1234;
    @(posedge clock); #1;
    check_eq("mthi_hi", 64'(hi), 64'h1234);
    check_eq("mthi_busy", 64'(busy), 64'd0);
    md_op = MD_MTLO; src_a = 32'h5678;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq("mtlo_lo", 64'(lo), 64'h5678);
    check_eq("mtlo_hi_kept", 64'(hi), 64'h1234);
    check_eq("mtlo_busy", 64'(busy), 64'd0);
    check_eq("mtlo_done", 64'(done), 64'd0);

    // Flush a DIVU while its iteration counter reads 10.
    sav_hi = hi; sav_lo = lo;
    @(negedge clock);
    start = 1'b1; md_op = MD_DIVU; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (11) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_done", 64'(done), 64'd0);
    no_done = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) no_done = 1'b0;
    end
    check_eq("flush_quiet", 64'(no_done), 64'd1);
    check_eq("flush_hi_kept", 64'(hi), 64'(sav_hi));
    check_eq("flush_lo_kept", 64'(lo), 64'(sav_lo));
    run_op("after_flush", MD_MULT, 32'd123456, 32'hFFFF_FF00, 1'b0);

    // Flush wins over a same-cycle start or MTHI in IDLE.
    sav_hi = hi;
    @(negedge clock);
    flush = 1'b1; start = 1'b1; md_op = MD_MULT; src_a = 32'd5; src_b = 32'd6;
    @(posedge clock); #1;
    check_eq("flush_start_busy", 64'(busy), 64'd0);
    md_op = MD_MTHI; src_a = 32'hCAFE_0000;
    @(posedge clock); #1;
    flush = 1'b0; start = 1'b0;
    check_eq("flush_mthi_hi", 64'(hi), 64'(sav_hi));
    check_eq("flush_start_busy2", 64'(busy), 64'd0);

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: begin ra = 32'($urandom_range(0, 50)); rb = 32'($signed(-$urandom_range(1, 9))); end
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of iteration.
    @(negedge clock);
    start = 1'b1; md_op = MD_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'h1234_5678;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_dbz", 64'(div_by_zero), 64'd0);
    check_eq("arst_hi", 64'(hi), 64'd0);
    check_eq("arst_lo", 64'(lo), 64'd0);
    @(negedge clock); rst_n = 1'b1;
    run_op("after_reset", MD_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
